serial_addsub: RTL and testbench

//  Parametrised digit-serial adder/subtractor. Parallel operands are captured on start,

---
 rtl/serial_arith_pkg.sv | 19 +
 rtl/serial_digit_add.sv | 27 ++
 rtl/serial_addsub.sv | 132 +++++++++++++
 tb/tb_serial_addsub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks.
//   state_t   : controller state encoding (IDLE / RUN / DONE)
//   cnt_width : bits needed for a counter that runs 0 .. n-1 (at least 1)
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_digit_add.sv
// Combinational DIGIT-bit adder used once per processing cycle.
// Ports:
//   x, y   in   DIGIT  digit operands
//   cin    in   1      carry in
//   s      out  DIGIT  digit sum
//   cout   out  1      carry out of the digit
//   c_msb  out  1      carry into bit DIGIT-1 of the digit
module serial_digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] w_full;

  assign w_full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign s      = w_full[DIGIT-1:0];
  assign cout   = w_full[DIGIT];
  // Carry into the top bit recovered from its sum bit; also correct for DIGIT==1 (gives cin).
  assign c_msb  = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Operands are captured on an accepted start,
// processed DIGIT bits per clock LSB-first through one carry flop, and the
// parallel result with carry and signed overflow is published on the done edge.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   start, sub   request and mode (0: a+b, 1: a-b), sampled when not busy
//   a, b         WIDTH-bit operands, sampled on the accepting edge
//   busy         high while processing digits
//   done         one-cycle pulse when results become valid
//   sum          WIDTH-bit result, held until the next operation completes
//   cout         final carry (for sub: 1 = no borrow)
//   ovf          signed overflow
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0] w_res_shift;

  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

  serial_digit_add #(.DIGIT(DIGIT)) u_digit (
    .x     (r_a[DIGIT-1:0]),
    .y     (r_b[DIGIT-1:0]),
    .cin   (r_carry),
    .s     (w_s),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  // New digit enters at the top; after NDIG shifts the result is aligned.
  assign w_cat       = {w_s, r_res};
  assign w_res_shift = w_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction as a + ~b + 1: the +1 enters through the carry flop.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_res   <= w_res_shift;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_res_shift;
        r_cout <= w_cout;
        r_ovf  <= w_c_msb ^ w_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic clk;
  logic reset;

  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width add of a and the (optionally inverted) b plus the mode bit.
  function automatic exp_t model(input int sel, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub);
    exp_t e;
    if (sel == 0) begin
      logic [7:0] bb;
      logic [8:0] full;
      bb     = sub ? ~b[7:0] : b[7:0];
      full   = {1'b0, a[7:0]} + {1'b0, bb} + {8'd0, sub};
      e.sum  = {8'd0, full[7:0]};
      e.cout = full[8];
      e.ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    end else begin
      logic [15:0] bb;
      logic [16:0] full;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
      e.sum  = full[15:0];
      e.cout = full[16];
      e.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
    end
    return e;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done8 : done16;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy8 : busy16;
  endfunction

  // Called at a negedge; drives start for one edge, then scrambles operands.
  task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input bit push);
    if (sel == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; start8 = 1'b1;
    end else begin
      a16 = a; b16 = b; sub16 = sub; start16 = 1'b1;
    end
    if (push) sb.push_back(model(sel, a, b, sub));
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    a8  = 8'($urandom);  b8  = 8'($urandom);  sub8  = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
  endtask

  task automatic wait_done(input int sel, input int bound, output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < bound; i++) begin
      chk("busy_done_excl", {31'd0, get_done(sel) & get_busy(sel)}, 32'd0);
      if (get_done(sel)) begin
        seen = 1'b1;
        break;
      end
      if (get_busy(sel)) nbusy++;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_result(input int sel, input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (sel == 0) begin
        chk({tag, "_sum"},  {24'd0, sum8}, {16'd0, e.sum});
        chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, e.cout});
        chk({tag, "_ovf"},  {31'd0, ovf8},  {31'd0, e.ovf});
      end else begin
        chk({tag, "_sum"},  {16'd0, sum16}, {16'd0, e.sum});
        chk({tag, "_cout"}, {31'd0, cout16}, {31'd0, e.cout});
        chk({tag, "_ovf"},  {31'd0, ovf16},  {31'd0, e.ovf});
      end
    end
  endtask

  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input int exp_busy, input string tag);
    int  n;
    bit  seen;
    issue(sel, a, b, sub, 1'b1);
    wait_done(sel, 40, n, seen);
    chk({tag, "_busy_cycles"}, n, exp_busy);
    check_result(sel, tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, get_done(sel)}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    int  dones;

    reset = 1'b1;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    start16 = 0; sub16 = 0; a16 = 0; b16 = 0;
    #1;
    chk("rst_busy",  {31'd0, busy8}, 32'd0);
    chk("rst_done",  {31'd0, done8}, 32'd0);
    chk("rst_sum",   {24'd0, sum8},  32'd0);
    chk("rst_cout",  {31'd0, cout8}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf8},  32'd0);
    chk("rst_sum16", {16'd0, sum16}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(0, 16'd11,  16'd19, 1'b0, 8, "add_11_19");
    run_op(0, 16'd200, 16'd100, 1'b0, 8, "add_200_100");
    run_op(0, 16'd127, 16'd1,  1'b0, 8, "add_127_1");
    run_op(0, 16'd5,   16'd7,  1'b1, 8, "sub_5_7");
    run_op(0, 16'd128, 16'd1,  1'b1, 8, "sub_128_1");
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 4, "w16_ffff_1");
    run_op(1, 16'h8000, 16'h0001, 1'b1, 4, "w16_sub_ovf");
    run_op(1, 16'h1234, 16'h4321, 1'b0, 4, "w16_add");

    for (int i = 0; i < 4; i++)
      run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom), 8, "rand8");

    // start during busy is ignored; start in the done cycle runs back-to-back
    issue(0, 16'd3, 16'd4, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(0, 40, n, seen);
    check_result(0, "ignore_busy_start");
    issue(0, 16'd20, 16'd22, 1'b1, 1'b1);
    chk("b2b_busy_now", {31'd0, busy8}, 32'd1);
    chk("b2b_no_done",  {31'd0, done8}, 32'd0);
    wait_done(0, 40, n, seen);
    chk("b2b_busy_cycles", n, 8);
    check_result(0, "b2b");
    @(negedge clk);

    // reset in the third RUN cycle abandons the operation
    issue(0, 16'd50, 16'd60, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy8}, 32'd0);
    chk("midrst_done", {31'd0, done8}, 32'd0);
    chk("midrst_sum",  {24'd0, sum8},  32'd0);
    chk("midrst_cout", {31'd0, cout8}, 32'd0);
    chk("midrst_ovf",  {31'd0, ovf8},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op(0, 16'd1, 16'd1, 1'b0, 8, "after_rst_1_1");

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
